// File: rtl/bitty_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitty_pkg
// Description : Shared encodings for the bitty branch unit: sequencer states,
//               opcode classes, branch conditions and compare constants.
// Revision    : 1.0 - initial release
// ============================================================================
package bitty_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_DECODE    = 2'd2,
    ST_WAIT_CORE = 2'd3
  } state_t;

  // Opcode class lives in instruction[1:0]; 2'b00/2'b01 go to the ALU core
  localparam logic [1:0] OP_BRANCH  = 2'b10;
  localparam logic [1:0] OP_CALLRET = 2'b11;

  // Branch condition lives in instruction[3:2]
  localparam logic [1:0] COND_EQ0    = 2'b00;
  localparam logic [1:0] COND_EQ1    = 2'b01;
  localparam logic [1:0] COND_EQ2    = 2'b10;
  localparam logic [1:0] COND_ALWAYS = 2'b11;

  // Values the latched ALU result is compared against
  localparam int CMP_ZERO = 0;
  localparam int CMP_ONE  = 1;
  localparam int CMP_TWO  = 2;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack. A push onto a full stack
//               overwrites the oldest entry; a pop of an empty stack is
//               refused. Both events raise sticky flags cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack
  import bitty_pkg::*;
#(
  parameter int PC_WIDTH  = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_WIDTH-1:0]        push_addr,
  output logic [PC_WIDTH-1:0]        top_addr,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    r_top;      // next slot to write
  logic [PTR_W:0]      r_count;
  logic                r_overflow;
  logic                r_underflow;
  logic [PTR_W-1:0]    w_top_idx;

  // Most recent entry sits just below the write pointer (wraps naturally)
  assign w_top_idx = r_top - PTR_W'(1);
  assign top_addr  = r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Entry storage; contents need no reset because count gates their use
  always_ff @(posedge clk) begin
    if (push) r_mem[r_top] <= push_addr;
  end

  // Pointer, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_top       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (push) begin
      r_top <= r_top + PTR_W'(1);
      if (r_count == C_FULL) r_overflow <= 1'b1;
      else                   r_count    <= r_count + (PTR_W+1)'(1);
    end else if (pop) begin
      if (r_count == '0) begin
        r_underflow <= 1'b1;
      end else begin
        r_top   <= w_top_idx;
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : Program-counter sequencer for the bitty processor. Fetches,
//               resolves branches/jumps/calls/returns locally and hands ALU
//               instructions to the core, latching each result for later
//               branch conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit
  import bitty_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [15:0]                instruction,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  input  logic                       done,
  output logic [PC_WIDTH-1:0]        pc,
  output logic                       core_run,
  output logic                       pc_update,
  output logic                       taken,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [DATA_WIDTH-1:0] r_last_result;
  logic                  r_core_run;
  logic                  r_pc_update;
  logic                  r_taken;

  logic [PC_WIDTH-1:0]   w_target;
  logic [PC_WIDTH-1:0]   w_pc_inc;
  logic [PC_WIDTH-1:0]   w_next_pc;
  logic [PC_WIDTH-1:0]   w_ras_top;
  logic                  w_ras_empty;
  logic                  w_cond_true;
  logic                  w_redirect;
  logic                  w_push;
  logic                  w_pop;

  assign w_target = instruction[PC_WIDTH+3:4];
  assign w_pc_inc = r_pc + PC_WIDTH'(1);

  // Target field does not reach the top instruction bits for narrow PCs
  if (PC_WIDTH < 12) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^instruction[15:PC_WIDTH+4];
  end

  // Condition evaluation against the registered ALU result
  always_comb begin
    w_cond_true = 1'b0;
    case (instruction[3:2])
      COND_EQ0:    w_cond_true = (r_last_result == DATA_WIDTH'(CMP_ZERO));
      COND_EQ1:    w_cond_true = (r_last_result == DATA_WIDTH'(CMP_ONE));
      COND_EQ2:    w_cond_true = (r_last_result == DATA_WIDTH'(CMP_TWO));
      COND_ALWAYS: w_cond_true = 1'b1;
      default:     w_cond_true = 1'b0;
    endcase
  end

  // Control-flow resolution in DECODE: next pc, redirect flag, RAS traffic
  always_comb begin
    w_next_pc  = w_pc_inc;
    w_redirect = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    if (r_state == ST_DECODE && run) begin
      case (instruction[1:0])
        OP_BRANCH: begin
          if (w_cond_true) begin
            w_redirect = 1'b1;
            w_next_pc  = w_target;
          end
        end
        OP_CALLRET: begin
          if (!instruction[2]) begin
            w_push     = 1'b1;
            w_redirect = 1'b1;
            w_next_pc  = w_target;
          end else begin
            w_pop = 1'b1;
            // Empty stack: fall through to pc+1 while the stack flags it
            if (!w_ras_empty) begin
              w_redirect = 1'b1;
              w_next_pc  = w_ras_top;
            end
          end
        end
        default: ;
      endcase
    end
  end

  ras_stack #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_addr (w_pc_inc),
    .top_addr  (w_ras_top),
    .count     (ras_count),
    .empty     (w_ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // Sequencer FSM with registered pc, result latch and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_last_result <= '0;
      r_core_run    <= 1'b0;
      r_pc_update   <= 1'b0;
      r_taken       <= 1'b0;
    end else begin
      r_pc_update <= 1'b0;
      r_taken     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          r_state <= run ? ST_DECODE : ST_IDLE;
        end
        ST_DECODE: begin
          if (!run) begin
            r_state <= ST_IDLE;
          end else if (instruction[1]) begin
            r_pc        <= w_next_pc;
            r_pc_update <= 1'b1;
            r_taken     <= w_redirect;
            r_state     <= ST_FETCH;
          end else begin
            r_core_run <= 1'b1;
            r_state    <= ST_WAIT_CORE;
          end
        end
        ST_WAIT_CORE: begin
          // Dropping run here does not abort; only done ends the wait
          if (done) begin
            r_last_result <= alu_result;
            r_pc          <= w_pc_inc;
            r_pc_update   <= 1'b1;
            r_core_run    <= 1'b0;
            r_state       <= run ? ST_FETCH : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pc        = r_pc;
  assign core_run  = r_core_run;
  assign pc_update = r_pc_update;
  assign taken     = r_taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_unit
// Description : Directed self-checking bench for branch_unit with a small
//               instruction memory and a hand-driven ALU core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic [15:0] alu_result;
  logic        done;
  logic [7:0]  pc;
  logic        core_run;
  logic        pc_update;
  logic        taken;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  logic [15:0] imem [256];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  assign instruction = imem[pc];

  branch_unit #(
    .PC_WIDTH   (8),
    .DATA_WIDTH (16),
    .RAS_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .instruction   (instruction),
    .alu_result    (alu_result),
    .done          (done),
    .pc            (pc),
    .core_run      (core_run),
    .pc_update     (pc_update),
    .taken         (taken),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch + decode of a control-flow instruction
  task automatic ctl();
    tick();
    tick();
  endtask

  // From FETCH at an ALU instruction: fetch, decode, then one-cycle core
  task automatic alu_done(input logic [15:0] res);
    tick();
    tick();
    done       = 1'b1;
    alu_result = res;
    tick();
    done       = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;   // ALU by default
    imem[8'h01] = 16'h0402;  // beq0 -> 0x40
    imem[8'h41] = 16'h0802;  // beq0 -> 0x80
    imem[8'h42] = 16'h0806;  // beq1 -> 0x80
    imem[8'h43] = 16'h080A;  // beq2 -> 0x80
    imem[8'h44] = 16'h010E;  // jump -> 0x10
    imem[8'h11] = 16'h0186;  // beq1 -> 0x18
    imem[8'h19] = 16'h005A;  // beq2 -> 0x05
    imem[8'h05] = 16'h0203;  // call 0x20
    imem[8'h20] = 16'h0007;  // ret
    imem[8'h06] = 16'h0303;  // call 0x30
    imem[8'h30] = 16'h0323;  // call 0x32
    imem[8'h32] = 16'h0343;  // call 0x34
    imem[8'h34] = 16'h0363;  // call 0x36
    imem[8'h36] = 16'h03A3;  // call 0x3A
    imem[8'h3A] = 16'h0007;
    imem[8'h37] = 16'h0007;
    imem[8'h35] = 16'h0007;
    imem[8'h33] = 16'h0007;
    imem[8'h31] = 16'h0007;

    reset = 1'b1; run = 1'b0; done = 1'b0; alu_result = 16'h0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_pc_update", pc_update, 0);
    chk("rst_taken", taken, 0);
    chk("rst_ras_count", ras_count, 0);
    chk("rst_flags", {ras_overflow, ras_underflow}, 0);

    // ALU at 0 yielding 0, then beq0 at 1 taken to 0x40
    run = 1'b1;
    tick(); tick(); tick();
    chk("alu0_core_run", core_run, 1);
    chk("alu0_pc", pc, 0);
    done = 1'b1; alu_result = 16'h0000;
    tick();
    done = 1'b0;
    chk("alu0_pc_next", pc, 1);
    chk("alu0_pc_update", pc_update, 1);
    chk("alu0_core_run_drop", core_run, 0);
    ctl();
    chk("beq0_pc", pc, 8'h40);
    chk("beq0_taken", taken, 1);
    tick();
    chk("beq0_taken_pulse", taken, 0);
    tick();
    done = 1'b1; alu_result = 16'h0005;
    tick();
    done = 1'b0;
    chk("alu5_pc", pc, 8'h41);

    // last_result = 5: all compares fail, jump always taken
    ctl(); chk("nt_eq0_pc", pc, 8'h42); chk("nt_eq0_taken", taken, 0);
    ctl(); chk("nt_eq1_pc", pc, 8'h43); chk("nt_eq1_taken", taken, 0);
    ctl(); chk("nt_eq2_pc", pc, 8'h44); chk("nt_eq2_taken", taken, 0);
    ctl(); chk("jmp_pc", pc, 8'h10);   chk("jmp_taken", taken, 1);

    // eq1 and eq2 taken paths
    alu_done(16'h0001); chk("alu1_pc", pc, 8'h11);
    ctl(); chk("beq1_pc", pc, 8'h18); chk("beq1_taken", taken, 1);
    alu_done(16'h0002);
    ctl(); chk("beq2_pc", pc, 8'h05); chk("beq2_taken", taken, 1);

    // Single call / return
    ctl(); chk("call_pc", pc, 8'h20); chk("call_count", ras_count, 1);
    ctl(); chk("ret_pc", pc, 8'h06); chk("ret_taken", taken, 1);
    chk("ret_count", ras_count, 0);
    chk("ret_flags", {ras_overflow, ras_underflow}, 0);

    // Five nested calls: 0x07 is pushed first and later overwritten
    ctl(); chk("nest1_pc", pc, 8'h30);
    ctl(); chk("nest2_pc", pc, 8'h32);
    ctl(); chk("nest3_pc", pc, 8'h34);
    imem[8'h32] = 16'h0FFE;  // reused after underflow: jump -> 0xFF
    ctl(); chk("nest4_count", ras_count, 4); chk("nest4_ovf", ras_overflow, 0);
    ctl(); chk("nest5_pc", pc, 8'h3A); chk("nest5_count", ras_count, 4);
    chk("nest5_ovf", ras_overflow, 1);
    ctl(); chk("pop1_pc", pc, 8'h37); chk("pop1_count", ras_count, 3);
    ctl(); chk("pop2_pc", pc, 8'h35);
    ctl(); chk("pop3_pc", pc, 8'h33);
    ctl(); chk("pop4_pc", pc, 8'h31); chk("pop4_count", ras_count, 0);
    chk("pop4_unf", ras_underflow, 0);
    ctl(); chk("pop5_pc", pc, 8'h32); chk("pop5_taken", taken, 0);
    chk("pop5_pc_update", pc_update, 1); chk("pop5_unf", ras_underflow, 1);

    // pc wrap on an ALU instruction at the top address
    ctl(); chk("jmp_ff_pc", pc, 8'hFF);
    alu_done(16'h0007); chk("wrap_pc", pc, 8'h00); chk("wrap_pc_update", pc_update, 1);

    // Drop run while the core is busy: the instruction still completes
    tick(); tick();
    run = 1'b0;
    tick(); tick();
    chk("norun_core_run", core_run, 1);
    chk("norun_pc", pc, 0);
    done = 1'b1; alu_result = 16'h0009;
    tick();
    done = 1'b0;
    chk("norun_done_pc", pc, 1);
    chk("norun_done_core_run", core_run, 0);
    // done while idle must not overwrite last_result (9)
    done = 1'b1; alu_result = 16'h0000;
    tick();
    done = 1'b0;
    tick(); tick();
    chk("idle_pc_frozen", pc, 1);
    chk("idle_pc_update", pc_update, 0);
    run = 1'b1;
    tick(); tick(); tick();
    chk("resume_pc", pc, 2);
    chk("resume_taken", taken, 0);

    // Reset while the core is busy
    tick(); tick();
    chk("mid_core_run", core_run, 1);
    chk("mid_sticky", {ras_overflow, ras_underflow}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_core_run", core_run, 0);
    chk("mid_rst_flags", {ras_overflow, ras_underflow}, 0);
    chk("mid_rst_count", ras_count, 0);
    done = 1'b1; alu_result = 16'h1234;
    tick();
    done = 1'b0;
    tick();
    chk("late_done_pc", pc, 0);
    chk("late_done_pc_update", pc_update, 0);
    chk("late_done_core_run", core_run, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
